alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 22 ++
 rtl/alu_16.sv | 48 ++++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_pkg
//  Purpose  : Shared types and opcode constants for the arbitrated ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    // Arbiter FSM: IDLE accepts a request, EXEC runs the shared datapath.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // ALU opcodes
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_16.sv
`default_nettype none
// ============================================================================
//  Module   : alu_16
//  Purpose  : 16-bit bit-slice ALU (add, sub, and, or) with carry-out.
//             Subtraction is a + ~b + 1, so carry-out 1 means no borrow.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_16 (
    input  logic [1:0]  i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y,
    output logic        o_cout
);
    import alu_arbiter_pkg::*;

    logic        w_sub;
    logic [15:0] w_bx;
    logic [15:0] w_sum;
    logic [16:0] w_c;

    assign w_sub  = (i_op == OP_SUB);
    // Inverting b and injecting a carry-in of 1 turns the adder into a subtractor.
    assign w_c[0] = w_sub;

    // One full-adder slice per bit, rippling the carry upward.
    for (genvar i = 0; i < 16; i++) begin : g_slice
        assign w_bx[i]    = i_b[i] ^ w_sub;
        assign w_sum[i]   = i_a[i] ^ w_bx[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & w_bx[i]) | (w_c[i] & (i_a[i] ^ w_bx[i]));
    end

    // Select the result for the requested operation; logic ops clear carry.
    always_comb begin
        o_y    = i_a | i_b;
        o_cout = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB: begin
                o_y    = w_sum;
                o_cout = w_c[16];
            end
            OP_AND:  o_y = i_a & i_b;
            default: o_y = i_a | i_b;
        endcase
    end

endmodule : alu_16
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Two-port arbiter sharing one alu_16 through an IDLE/EXEC FSM.
//             gnt follows the sampling edge by one cycle, done by two.
//             FAIR=1 round-robin on ties, FAIR=0 fixed priority to port 0.
//  Options  : ALU_ARBITER_ZERO_FLAG_EN adds registered output 'zero'.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        c_out
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    ,
    output logic        zero
`endif
);
    import alu_arbiter_pkg::*;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_take;          // accept a request this edge
    logic        w_pick;          // winning port: 0 or 1
    logic        w_finish;        // capture ALU output this edge
    logic        r_last_winner;   // port granted most recently
    logic        r_owner;         // port whose operation is in flight
    logic [1:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done0;
    logic        r_done1;
    logic [15:0] r_result;
    logic        r_c_out;
    logic [15:0] w_alu_y;
    logic        w_alu_c;

    alu_16 u_alu (
        .i_op   (r_op),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_y    (w_alu_y),
        .o_cout (w_alu_c)
    );

    // Next-state and arbitration decision.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_pick       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_take       = 1'b1;
                    w_state_next = EXEC;
                    if (req0 && req1)
                        w_pick = FAIR ? ~r_last_winner : 1'b0;
                    else
                        w_pick = req1;
                end
            end
            EXEC: begin
                w_finish     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Operand latch, strobes and registered results; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_result      <= 16'h0000;
            r_c_out       <= 1'b0;
            r_last_winner <= 1'b1;
            r_owner       <= 1'b0;
            r_op          <= OP_ADD;
            r_a           <= 16'h0000;
            r_b           <= 16'h0000;
        end else begin
            r_gnt0  <= w_take & ~w_pick;
            r_gnt1  <= w_take & w_pick;
            r_done0 <= w_finish & ~r_owner;
            r_done1 <= w_finish & r_owner;
            if (w_take) begin
                r_owner       <= w_pick;
                r_last_winner <= w_pick;
                r_op          <= w_pick ? op1 : op0;
                r_a           <= w_pick ? a1  : a0;
                r_b           <= w_pick ? b1  : b0;
            end
            if (w_finish) begin
                r_result <= w_alu_y;
                r_c_out  <= w_alu_c;
            end
        end
    end

`ifdef ALU_ARBITER_ZERO_FLAG_EN
    logic r_zero;

    // Zero flag captured alongside the result.
    always_ff @(posedge clk) begin
        if (reset)
            r_zero <= 1'b0;
        else if (w_finish)
            r_zero <= (w_alu_y == 16'h0000);
    end

    assign zero = r_zero;
`endif

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign done0  = r_done0;
    assign done1  = r_done1;
    assign result = r_result;
    assign c_out  = r_c_out;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Directed self-checking bench for alu_arbiter; a round-robin
//             (FAIR=1) and a fixed-priority (FAIR=0) instance share inputs.
//  Options  : ALU_ARBITER_ZERO_FLAG_EN also checks the 'zero' output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;

    logic        gnt0, gnt1, done0, done1, c_out;
    logic [15:0] result;
    logic        f_gnt0, f_gnt1, f_done0, f_done1, f_c_out;
    logic [15:0] f_result;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    logic        zero, f_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.FAIR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .c_out(c_out)
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    alu_arbiter #(.FAIR(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
        .result(f_result), .c_out(f_c_out)
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        , .zero(f_zero)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on a single port, checking gnt, done and outputs.
    task automatic do_op(input logic port, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_y, input logic exp_c, input string tag);
        if (port) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else      begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        step();
        check({tag, " gnt"}, {30'd0, gnt1, gnt0}, port ? 32'd2 : 32'd1);
        check({tag, " fp gnt"}, {30'd0, f_gnt1, f_gnt0}, port ? 32'd2 : 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        check({tag, " done"}, {30'd0, done1, done0}, port ? 32'd2 : 32'd1);
        check({tag, " result"}, {16'd0, result}, {16'd0, exp_y});
        check({tag, " c_out"}, {31'd0, c_out}, {31'd0, exp_c});
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        check({tag, " zero"}, {31'd0, zero}, {31'd0, (exp_y == 16'h0000)});
`endif
        step();
        check({tag, " hold"}, {12'd0, done1, done0, gnt1, gnt0, result},
              {16'd0, exp_y});
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'd0; op1 = 2'd0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step();
        step();
        check("reset outputs", {12'd0, gnt1, gnt0, done1, done0, result, c_out, 3'd0}, 32'd0);
        reset = 1'b0;
        step();
        check("idle no req", {28'd0, gnt1, gnt0, done1, done0}, 32'd0);

        // Directed arithmetic/logic vectors
        do_op(1'b0, 2'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, "add p0");
        do_op(1'b1, 2'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, "sub borrow p1");
        do_op(1'b1, 2'd1, 16'h0007, 16'h0005, 16'h0002, 1'b1, "sub p1");
        do_op(1'b0, 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, "add wrap");
        do_op(1'b1, 2'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, "and p1");
        do_op(1'b0, 2'd3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, "or p0");
        do_op(1'b1, 2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, "add msb");

        // Both ports held high from reset release
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        op0 = 2'd0; a0 = 16'h0001; b0 = 16'h0001;
        op1 = 2'd0; a1 = 16'h0010; b1 = 16'h0010;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 1) begin
                check($sformatf("tie rr gnt %0d", k), {30'd0, gnt1, gnt0},
                      (k % 4 == 1) ? 32'd1 : 32'd2);
                check($sformatf("tie fp gnt %0d", k), {30'd0, f_gnt1, f_gnt0}, 32'd1);
            end else begin
                check($sformatf("tie rr done %0d", k), {28'd0, gnt1, gnt0, done1, done0},
                      (k % 4 == 2) ? 32'd1 : 32'd2);
                check($sformatf("tie rr result %0d", k), {16'd0, result},
                      (k % 4 == 2) ? 32'h0002 : 32'h0020);
                check($sformatf("tie fp done %0d", k), {28'd0, f_gnt1, f_gnt0, f_done1, f_done0},
                      32'd1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Reset pulsed during EXEC discards the op; reset also beats a pending request
        req0 = 1'b1; op0 = 2'd0; a0 = 16'h0003; b0 = 16'h0004;
        step();
        check("rst-exec gnt", {30'd0, gnt1, gnt0}, 32'd1);
        reset = 1'b1;
        step();
        check("rst-exec during", {11'd0, gnt1, gnt0, done1, done0, result, c_out}, 32'd0);
        reset = 1'b0;
        req0 = 1'b0;
        step();
        check("rst-exec no done", {11'd0, gnt1, gnt0, done1, done0, result, c_out}, 32'd0);
        step();
        check("rst-exec still idle", {28'd0, gnt1, gnt0, done1, done0}, 32'd0);
        do_op(1'b0, 2'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, "after rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
